// File: rtl/bcd_update_sequencer.sv
// bcd_update_sequencer
// Registered binary-to-BCD converter that sits between the CPU OUT port and
// the 7-segment scanner. It watches bin_in and starts a conversion when the
// value changes or a refresh is requested. The conversion is a serial
// shift-and-add-3 (double-dabble) that processes one bit per clock. The last
// finished result is held on bcd_out until the next done pulse.
// "force" is a reserved word in SystemVerilog, so the refresh request port is
// named force_req.
module bcd_update_sequencer #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic [WIDTH-1:0]      bin_in,
   input  logic                  force_req,
   input  logic                  freeze,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // The decimal range must cover the largest binary input, or the top digit
   // would silently overflow.
   localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
   localparam longint unsigned BIN_MAX   = (64'd1 << WIDTH) - 64'd1;

   if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
      $error("bcd_update_sequencer: DIGITS too small for WIDTH");
   end

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    shift_reg;
   logic [WIDTH-1:0]    last_bin;
   logic [BW-1:0]       acc;
   logic [CW-1:0]       count;
   logic                pending;

   logic [BW-1:0]       adj;
   logic [BW+WIDTH-1:0] cat_n;
   logic                start;

   // Per-digit add-3 correction. A digit of 5 or more becomes 8 or more, so
   // the following shift carries correctly into the next decade.
   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      assign adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3
                                                     : acc[4*d +: 4];
   end

   // One double-dabble step. The binary MSB moves into the BCD LSB.
   assign cat_n = {adj, shift_reg} << 1;

   // A refresh remembered in pending counts the same as a new request.
   // Freeze only gates the start, so requests still queue while frozen.
   assign start = !freeze && ((bin_in != last_bin) || force_req || pending);

   // Control FSM and datapath registers. All outputs are registered.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         shift_reg <= '0;
         last_bin  <= '0;
         acc       <= '0;
         count     <= '0;
         pending   <= 1'b0;
         bcd_out   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= bin_in;
                  last_bin  <= bin_in;
                  acc       <= '0;
                  count     <= CW'(WIDTH - 1);
                  pending   <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end else if (force_req) begin
                  // A refresh requested while frozen is held until release.
                  pending <= 1'b1;
               end
            end
            SHIFT: begin
               acc       <= cat_n[BW+WIDTH-1:WIDTH];
               shift_reg <= cat_n[WIDTH-1:0];
               count     <= count - 1'b1;
               if (force_req) pending <= 1'b1;
               if (count == '0) begin
                  // Only the complete result is published.
                  bcd_out <= cat_n[BW+WIDTH-1:WIDTH];
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_update_sequencer.sv
// Directed bench for bcd_update_sequencer (WIDTH=8, DIGITS=3).
// Inputs change on the falling edge. Outputs are checked on the falling edge.
module tb_bcd_update_sequencer;

   logic        clock;
   logic        nReset;
   logic [7:0]  bin_in;
   logic        force_req;
   logic        freeze;
   logic [11:0] bcd_out;
   logic        busy;
   logic        done;

   int checks;
   int errors;
   int done_cnt;
   int busy_cnt;
   int overlap_cnt;

   bcd_update_sequencer #(.WIDTH(8), .DIGITS(3)) dut (
      .clock     (clock),
      .nReset    (nReset),
      .bin_in    (bin_in),
      .force_req (force_req),
      .freeze    (freeze),
      .bcd_out   (bcd_out),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count done pulses, busy cycles, and any done/busy overlap.
   always @(posedge clock) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (done && busy) overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // Call this on a falling edge. It applies val, checks busy for the 8
   // SHIFT cycles, then checks the done edge and the result.
   task automatic convert(input string tag, input logic [7:0] val, input logic [11:0] exp);
      bin_in = val;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      @(negedge clock);
      chk({tag, "_done"}, {30'd0, done, busy}, 32'd2);
      chk({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp});
   endtask

   // Wait a bounded number of cycles for done. A timeout counts as a failure.
   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      while (!done && n < max) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_seen"}, {31'd0, done}, 32'd1);
   endtask

   int d0;

   initial begin
      checks = 0; errors = 0; done_cnt = 0; busy_cnt = 0; overlap_cnt = 0;
      nReset = 1'b0; bin_in = 8'd0; force_req = 1'b0; freeze = 1'b0;

      // 1: reset state, then 20 idle cycles with bin_in=0.
      cyc(3);
      chk("rst_bcd", {20'd0, bcd_out}, 32'h000);
      chk("rst_flags", {30'd0, busy, done}, 32'd0);
      nReset = 1'b1;
      cyc(20);
      chk("idle0_bcd", {20'd0, bcd_out}, 32'h000);
      chk("idle0_done", done_cnt, 0);
      chk("idle0_busy", busy_cnt, 0);

      // 2: basic conversion with exact latency.
      convert("c137", 8'd137, 12'h137);
      @(negedge clock);
      chk("c137_pulse", {31'd0, done}, 32'd0);

      // 3: maximum, zero, single digit. One done per change.
      d0 = done_cnt;
      convert("c255", 8'd255, 12'h255);
      cyc(2);
      convert("c000", 8'd0, 12'h000);
      cyc(2);
      convert("c009", 8'd9, 12'h009);
      cyc(5);
      chk("c3_count", done_cnt - d0, 3);

      // 4: bin_in changes mid-conversion. The captured value is kept, then
      // the new value is converted.
      bin_in = 8'd10;
      cyc(4);
      bin_in = 8'd200;
      cyc(5);
      chk("mid_done1", {31'd0, done}, 32'd1);
      chk("mid_bcd1", {20'd0, bcd_out}, 32'h010);
      cyc(1);
      chk("mid_restart", {30'd0, busy, done}, 32'd2);
      cyc(8);
      chk("mid_done2", {31'd0, done}, 32'd1);
      chk("mid_bcd2", {20'd0, bcd_out}, 32'h200);

      // 5: force in IDLE with a stable value, then force with a change.
      cyc(2);
      convert("c042", 8'd42, 12'h042);
      cyc(3);
      d0 = done_cnt;
      force_req = 1'b1;
      cyc(1);
      force_req = 1'b0;
      wait_done("frc", 12);
      chk("frc_bcd", {20'd0, bcd_out}, 32'h042);
      cyc(15);
      chk("frc_count", done_cnt - d0, 1);
      d0 = done_cnt;
      force_req = 1'b1; bin_in = 8'd43;
      cyc(1);
      force_req = 1'b0;
      wait_done("frc2", 12);
      chk("frc2_bcd", {20'd0, bcd_out}, 32'h043);
      cyc(15);
      chk("frc2_count", done_cnt - d0, 1);

      // 5b: force during SHIFT leaves pending set, which causes a back-to-back
      // reconversion.
      d0 = done_cnt;
      bin_in = 8'd50;
      cyc(3);
      force_req = 1'b1;
      cyc(1);
      force_req = 1'b0;
      cyc(5);
      chk("pend_done1", {31'd0, done}, 32'd1);
      cyc(1);
      chk("pend_restart", {31'd0, busy}, 32'd1);
      cyc(8);
      chk("pend_done2", {31'd0, done}, 32'd1);
      chk("pend_bcd", {20'd0, bcd_out}, 32'h050);
      cyc(15);
      chk("pend_count", done_cnt - d0, 2);

      // 6: freeze holds off the change, which runs after release.
      convert("c005", 8'd5, 12'h005);
      cyc(2);
      d0 = done_cnt;
      freeze = 1'b1; bin_in = 8'd99;
      cyc(30);
      chk("frz_count", done_cnt - d0, 0);
      chk("frz_busy", {31'd0, busy}, 32'd0);
      chk("frz_bcd", {20'd0, bcd_out}, 32'h005);
      freeze = 1'b0;
      convert("c099", 8'd99, 12'h099);

      // 6b: a reset during SHIFT aborts the conversion with no done pulse.
      cyc(2);
      d0 = done_cnt;
      bin_in = 8'd123;
      cyc(5);
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      #1 nReset = 1'b0;
      #1;
      chk("abort_outs", {18'd0, bcd_out, busy, done}, 32'd0);
      bin_in = 8'd0;
      cyc(2);
      nReset = 1'b1;
      cyc(20);
      chk("abort_nodone", done_cnt - d0, 0);
      chk("abort_bcd", {20'd0, bcd_out}, 32'h000);

      chk("never_overlap", overlap_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case anything hangs.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
